// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder sequencer. It computes {cout,sum} = a + b + cin by reusing
// a single 1-bit full adder. The adder handles one bit per clock, LSB first,
// and needs WIDTH clocks per operation. The requester side uses a start/done
// handshake: a request is accepted only while the block is idle, and requests
// that arrive while busy are dropped.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request, accepted only when busy=0
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cin    in   carry-in, sampled on the accepting edge
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  WIDTH-bit registered result, held until the next completion
//   cout   out  registered carry-out of the MSB, held with sum
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // cnt reaches at most WIDTH (on the exit edge), so clog2+1 bits never wrap.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] shreg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] shreg_nxt;
  logic             last;

  // The shared 1-bit full adder works on the current LSBs and the carry flop.
  always_comb begin
    fa_s = opa[0] ^ opb[0] ^ carry;
    fa_c = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  end

  // New sum bit enters at the MSB. After WIDTH shifts, the first (LSB) result
  // bit has reached bit 0. Writing the shift as a truncated right shift of
  // {s, shreg} keeps it legal when WIDTH=1, where it reduces to shreg = s.
  assign shreg_nxt = WIDTH'({fa_s, shreg} >> 1);
  assign last      = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      shreg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            shreg <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          shreg <= shreg_nxt;
          carry <= fa_c;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          cnt   <= cnt + 1'b1;
          // Outputs are loaded only here, so partial results never reach sum/cout.
          if (last) begin
            sum   <= shreg_nxt;
            cout  <= fa_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  // WIDTH=8 instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    int          cy;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("spurious_done8", 32'(q8.size()), 32'd1);
      else begin
        e = q8.pop_front();
        chk("sum8", 32'(sum8), e.s);
        chk("cout8", 32'(cout8), 32'(e.c));
        chk("done_cyc8", 32'(cyc), 32'(e.cy));
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("spurious_done1", 32'(q1.size()), 32'd1);
      else begin
        e = q1.pop_front();
        chk("sum1", 32'(sum1), e.s);
        chk("cout1", 32'(cout1), 32'(e.c));
        chk("done_cyc1", 32'(cyc), 32'(e.cy));
      end
    end
  end

  // Expected result for an op accepted on the edge after the current negedge.
  task automatic push8(input logic [7:0] x, input logic [7:0] y, input logic c, input int acc_cyc);
    exp_t e;
    logic [8:0] r;
    r = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.s = {24'd0, r[7:0]};
    e.c = r[8];
    e.cy = acc_cyc + 8;
    q8.push_back(e);
  endtask

  task automatic push1(input logic x, input logic y, input logic c);
    exp_t e;
    logic [1:0] r;
    r = {1'b0, x} + {1'b0, y} + {1'b0, c};
    e.s = {31'd0, r[0]};
    e.c = r[1];
    e.cy = cyc + 1 + 1;
    q1.push_back(e);
  endtask

  task automatic drain8();
    int t = 0;
    while (q8.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (q8.size() != 0) begin
      chk("timeout8", 32'(q8.size()), 32'd0);
      q8.delete();
    end
    @(negedge clk);  // let DONE return to IDLE before the next request
  endtask

  task automatic drain1();
    int t = 0;
    while (q1.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (q1.size() != 0) begin
      chk("timeout1", 32'(q1.size()), 32'd0);
      q1.delete();
    end
    @(negedge clk);
  endtask

  // Called on a negedge with the WIDTH=8 instance idle.
  task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic c);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    push8(x, y, c, cyc + 1);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    drain8();
  endtask

  task automatic go1(input logic x, input logic y, input logic c);
    a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
    push1(x, y, c);
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    drain1();
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_cout8", 32'(cout8), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_sum1", 32'(sum1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5A+33: busy must be high for exactly 9 cycles.
    a8 = 8'h5A; b8 = 8'h33; cin8 = 0; start8 = 1;
    push8(8'h5A, 8'h33, 1'b0, cyc + 1);
    @(negedge clk);
    start8 = 0;
    chk("busy_t1_0", 32'(busy8), 32'd1);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      chk("busy_t1", 32'(busy8), 32'd1);
    end
    @(negedge clk);
    chk("busy_t1_end", 32'(busy8), 32'd0);
    drain8();

    go8(8'hFF, 8'h01, 1'b0);
    go8(8'hFF, 8'hFF, 1'b1);
    go8(8'h00, 8'h00, 1'b1);

    // Start while busy is dropped, and operand changes mid-run have no effect.
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    push8(8'h10, 8'h20, 1'b0, cyc + 1);
    @(negedge clk); start8 = 0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; start8 = 1;
    @(negedge clk); start8 = 0; a8 = 8'h5C; b8 = 8'hC3;
    drain8();
    repeat (3) @(negedge clk);

    // Reset mid-RUN with start asserted on the reset edge.
    a8 = 8'hAA; b8 = 8'h77; cin8 = 1; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (4) @(negedge clk);  // cnt = 4 now
    rst_n = 0; start8 = 1; a8 = 8'h01; b8 = 8'h01; cin8 = 0;
    @(negedge clk);
    rst_n = 1; start8 = 0;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_cout", 32'(cout8), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_idle", 32'(busy8), 32'd0);
    go8(8'h01, 8'h01, 1'b0);

    // Continuous start: re-accepted every WIDTH+2 cycles.
    base = cyc;
    a8 = 8'h7F; b8 = 8'h01; cin8 = 0; start8 = 1;
    for (int j = 0; j < 4; j++) push8(8'h7F, 8'h01, 1'b0, base + 1 + 10 * j);
    repeat (35) @(negedge clk);
    start8 = 0;
    drain8();

    for (int i = 0; i < 1000; i++)
      go8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      go1(1'($urandom), 1'($urandom), 1'($urandom));

    repeat (5) @(negedge clk);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
